// File: rtl/truth_table_checker_if.sv
// Handshake and observation bundle between a sweep controller and the
// truth-table checker. The checker drives stim and the result signals; the
// other side supplies start and the DUT response.
interface truth_table_checker_if #(
  parameter int N_IN = 3
);
  logic            start;
  logic [N_IN-1:0] stim;
  logic            resp;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_idx;
  logic            first_fail_vld;

  // Harness side: requests sweeps, returns the DUT response, watches results.
  modport master (
    output start,
    output resp,
    input  stim,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_fail_idx,
    input  first_fail_vld
  );

  // Checker side.
  modport slave (
    input  start,
    input  resp,
    output stim,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_fail_idx,
    output first_fail_vld
  );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table checker: walks every input vector onto stim, holds
// each for SETTLE_CYC cycles, samples the 1-bit DUT response on the last of
// those cycles and compares it against the EXPECT table. Reports pass/fail,
// the number of mismatching vectors and the lowest failing vector index.
module truth_table_checker #(
  parameter int                       N_IN       = 3,
  parameter logic [(2**N_IN)-1:0]     EXPECT     = 8'hD5,
  parameter int                       SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  truth_table_checker_if.slave bus
);

  // Settle counter must hold SETTLE_CYC-1; keep at least one bit when it is 0.
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0]  IDX_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_count_q, err_count_d;
  logic [N_IN-1:0] first_fail_idx_q, first_fail_idx_d;
  logic            first_fail_vld_q, first_fail_vld_d;

  logic sample_now;
  logic last_vec;
  logic mismatch;
  logic start_ok;

  // Decode the sampling edge, last vector and whether a start is accepted.
  always_comb begin
    sample_now = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    last_vec   = (idx_q == IDX_LAST);
    // Four-state compare so an X/Z response is treated as a mismatch.
    mismatch   = sample_now && (bus.resp !== EXPECT[idx_q]);
    start_ok   = bus.start && (state_q != ST_RUN);
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      cnt_q            <= '0;
      stim_q           <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= '0;
      first_fail_idx_q <= '0;
      first_fail_vld_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      stim_q           <= stim_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_count_q      <= err_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      first_fail_vld_q <= first_fail_vld_d;
    end
  end

  // Next-state: a start in IDLE or DONE launches a sweep; RUN ends after the
  // last vector has been sampled. Starts during RUN are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sample_now && last_vec) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath: settle counting, vector stepping and result accumulation.
  always_comb begin
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    stim_d           = stim_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;
    err_count_d      = err_count_q;
    first_fail_idx_d = first_fail_idx_q;
    first_fail_vld_d = first_fail_vld_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        stim_d = '0;
        if (start_ok) begin
          // A restart from DONE wipes the previous sweep's results.
          idx_d            = '0;
          cnt_d            = '0;
          err_count_d      = '0;
          first_fail_idx_d = '0;
          first_fail_vld_d = 1'b0;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          busy_d           = 1'b1;
        end
      end
      ST_RUN: begin
        if (!sample_now) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (mismatch) begin
            // Width holds 2**N_IN, so at most one increment per vector never wraps.
            err_count_d = err_count_q + (N_IN+1)'(1);
            if (!first_fail_vld_q) begin
              first_fail_idx_d = idx_q;
              first_fail_vld_d = 1'b1;
            end
          end
          if (last_vec) begin
            // Verdict uses the count including the vector just sampled.
            idx_d  = '0;
            stim_d = '0;
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_count_d == '0);
          end else begin
            idx_d  = idx_q + N_IN'(1);
            stim_d = idx_q + N_IN'(1);
          end
        end
      end
      default: begin
        stim_d = '0;
      end
    endcase
  end

  // All outputs come straight from flops.
  assign bus.stim           = stim_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_count_q;
  assign bus.first_fail_idx = first_fail_idx_q;
  assign bus.first_fail_vld = first_fail_vld_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (SETTLE_CYC=2 and 1) each fed
// by a modelled DUT f=(x&y)|~z with a per-run fault mask, checked every cycle
// against a behavioural model plus hand-computed literal results.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v [2];
  logic [7:0] fmask   [2];

  logic       busy_w [2];
  logic       done_w [2];
  logic       pass_w [2];
  logic [3:0] err_w  [2];
  logic [2:0] ffi_w  [2];
  logic       ffv_w  [2];
  logic [2:0] stim_w [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Reference function: {x,y,z} = i[2:0], f = (x&y)|~z.
  function automatic logic spec_f(input int i);
    logic x, y, z;
    x = ((i >> 2) & 1) != 0;
    y = ((i >> 1) & 1) != 0;
    z = (i & 1) != 0;
    return (x & y) | ~z;
  endfunction

  // Modelled DUT: the golden function with the fault-mask bits flipped.
  function automatic logic dut_f(input int i, input logic [7:0] m);
    return spec_f(i) ^ m[i[2:0]];
  endfunction

  task automatic chk(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int S = (gi == 0) ? 2 : 1;

    truth_table_checker_if #(.N_IN(3)) bus ();

    truth_table_checker #(
      .N_IN      (3),
      .EXPECT    (8'hD5),
      .SETTLE_CYC(S)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );

    assign bus.start = start_v[gi];
    assign bus.resp  = dut_f(int'(bus.stim), fmask[gi]);

    assign busy_w[gi] = bus.busy;
    assign done_w[gi] = bus.done;
    assign pass_w[gi] = bus.pass;
    assign err_w[gi]  = bus.err_count;
    assign ffi_w[gi]  = bus.first_fail_idx;
    assign ffv_w[gi]  = bus.first_fail_vld;
    assign stim_w[gi] = bus.stim;

    // Model: only tracks whether a sweep is running and how many edges
    // have elapsed since the accepting edge; everything else is derived.
    logic       m_run  = 1'b0;
    logic       m_done = 1'b0;
    int         m_t    = 0;
    logic [7:0] m_mask = 8'h00;

    always @(posedge clk) begin
      if (rst) begin
        m_run  <= 1'b0;
        m_done <= 1'b0;
        m_t    <= 0;
      end else if (!m_run && start_v[gi]) begin
        m_run  <= 1'b1;
        m_done <= 1'b0;
        m_t    <= 0;
        m_mask <= fmask[gi];
      end else if (m_run) begin
        if (m_t + 1 == S * 8) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
        end
        m_t <= m_t + 1;
      end
    end

    // Per-cycle comparison: vectors completed so far = elapsed edges / S.
    always @(negedge clk) begin : cmp
      int   k, e, ff;
      logic fv;
      if (rst) begin
        chk("rst_busy", gi, int'(bus.busy), 0);
        chk("rst_done", gi, int'(bus.done), 0);
        chk("rst_pass", gi, int'(bus.pass), 0);
        chk("rst_stim", gi, int'(bus.stim), 0);
        chk("rst_err",  gi, int'(bus.err_count), 0);
        chk("rst_ffi",  gi, int'(bus.first_fail_idx), 0);
        chk("rst_ffv",  gi, int'(bus.first_fail_vld), 0);
      end else begin
        k  = (m_run || m_done) ? (m_t / S) : 0;
        e  = 0;
        ff = 0;
        fv = 1'b0;
        for (int i = 0; i < k; i++) begin
          if (dut_f(i, m_mask) != spec_f(i)) begin
            e++;
            if (!fv) begin
              fv = 1'b1;
              ff = i;
            end
          end
        end
        chk("busy", gi, int'(bus.busy), int'(m_run));
        chk("done", gi, int'(bus.done), int'(m_done));
        chk("pass", gi, int'(bus.pass), (m_done && e == 0) ? 1 : 0);
        chk("stim", gi, int'(bus.stim), m_run ? (m_t / S) : 0);
        chk("err",  gi, int'(bus.err_count), e);
        chk("ffi",  gi, int'(bus.first_fail_idx), ff);
        chk("ffv",  gi, int'(bus.first_fail_vld), int'(fv));
      end
    end
  end

  // Launch a sweep on one instance and return the edges from the accepting
  // edge to done. restart_at>0 re-pulses start after that many edges.
  task automatic run_sweep(input int inst, input logic [7:0] m, input int restart_at,
                           output int edges);
    @(posedge clk);
    #1;
    fmask[inst]   = m;
    start_v[inst] = 1'b1;
    @(posedge clk);
    #1;
    start_v[inst] = 1'b0;
    chk("busy_after_accept", inst, int'(busy_w[inst]), 1);
    chk("done_after_accept", inst, int'(done_w[inst]), 0);
    edges = 0;
    while (edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == restart_at)     start_v[inst] = 1'b1;
      if (edges == restart_at + 1) start_v[inst] = 1'b0;
      if (done_w[inst]) break;
    end
    start_v[inst] = 1'b0;
    chk("done_seen", inst, int'(done_w[inst]), 1);
    $display("sweep inst%0d mask=%02h edges=%0d pass=%0d err=%0d ffi=%0d ffv=%0d",
             inst, m, edges, pass_w[inst], err_w[inst], ffi_w[inst], ffv_w[inst]);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    fmask[0]   = 8'h00;
    fmask[1]   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", 0, int'(done_w[0]), 0);
    chk("reset_stim", 0, int'(stim_w[0]), 0);
    rst = 1'b0;

    // Golden DUT.
    run_sweep(0, 8'h00, -1, n);
    chk("t1_latency", 0, n, 16);
    chk("t1_pass", 0, int'(pass_w[0]), 1);
    chk("t1_err",  0, int'(err_w[0]), 0);
    chk("t1_ffv",  0, int'(ffv_w[0]), 0);

    // Inverted DUT.
    run_sweep(0, 8'hFF, -1, n);
    chk("t2_pass", 0, int'(pass_w[0]), 0);
    chk("t2_err",  0, int'(err_w[0]), 8);
    chk("t2_ffi",  0, int'(ffi_w[0]), 0);
    chk("t2_ffv",  0, int'(ffv_w[0]), 1);

    // Wrong only at 5 and 6.
    run_sweep(0, 8'h60, -1, n);
    chk("t3_err",  0, int'(err_w[0]), 2);
    chk("t3_ffi",  0, int'(ffi_w[0]), 5);
    chk("t3_pass", 0, int'(pass_w[0]), 0);

    // Start re-pulsed mid-run is ignored.
    run_sweep(0, 8'h60, 6, n);
    chk("t4_latency", 0, n, 16);
    chk("t4_err", 0, int'(err_w[0]), 2);
    chk("t4_ffi", 0, int'(ffi_w[0]), 5);

    // Reset at edge 9 of a run, with one failure already recorded.
    @(posedge clk);
    #1;
    fmask[0]   = 8'h01;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("t5_err_before", 0, int'(err_w[0]), 1);
    chk("t5_stim_before", 0, int'(stim_w[0]), 4);
    rst = 1'b1;
    #1;
    chk("t5_busy", 0, int'(busy_w[0]), 0);
    chk("t5_stim", 0, int'(stim_w[0]), 0);
    chk("t5_err",  0, int'(err_w[0]), 0);
    chk("t5_ffv",  0, int'(ffv_w[0]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_sweep(0, 8'h00, -1, n);
    chk("t5_latency", 0, n, 16);
    chk("t5_pass", 0, int'(pass_w[0]), 1);

    // SETTLE_CYC=1 instance, then a restart from DONE.
    run_sweep(1, 8'h00, -1, n);
    chk("t6_latency", 1, n, 8);
    chk("t6_pass", 1, int'(pass_w[1]), 1);
    run_sweep(1, 8'h00, -1, n);
    chk("t6_latency2", 1, n, 8);

    // Randomized fault masks, instances and occasional mid-run restarts.
    for (int r = 0; r < 16; r++) begin
      int         inst, ra;
      logic [7:0] m;
      inst = int'($urandom_range(0, 1));
      m    = 8'($urandom);
      ra   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
      run_sweep(inst, m, ra, n);
      chk("rnd_latency", inst, n, (inst == 0) ? 16 : 8);
      chk("rnd_err", inst, int'(err_w[inst]), $countones(m ^ 8'h00));
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
